// File: rtl/dm_access.sv
// Load/store unit between the core and a word-wide request/acknowledge data bus.
// Builds byte enables and replicated store data, extends load data, and stalls the core until each access ends.
module dm_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  LAddr,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Stall,
  output logic        AddrErr,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  laddr_q;
  logic [1:0]  off_q;
  logic        misal_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;

  logic        is_store;
  logic        valid;
  size_t       size;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_ext;
  logic        stall_c;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A store takes priority over a simultaneous read request.
  always_comb begin
    is_store = (MemWrite != 2'b00);
    valid    = MemRead | is_store;
    size     = SZ_WORD;
    if (is_store) begin
      case (MemWrite)
        2'b10:   size = SZ_BYTE;
        2'b11:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (LAddr)
        3'b001, 3'b010: size = SZ_BYTE;
        3'b011, 3'b100: size = SZ_HALF;
        default:        size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = 32'h0;
    case (size)
      SZ_BYTE: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {4{WData[7:0]}};
      end
      SZ_HALF: begin
        misaligned = Addr[0];
        be_new     = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{WData[15:0]}};
      end
      default: begin
        misaligned = (Addr[1:0] != 2'b00);
        be_new     = 4'b1111;
        wdata_new  = WData;
      end
    endcase
    if (!is_store) wdata_new = 32'h0;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = bus_rdata[8*gi +: 8];
  end

  assign byte_sel = rd_lane[off_q];
  assign half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (laddr_q)
      3'b001:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_ext = {24'h0, byte_sel};
      3'b011:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {16'h0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // An ack arriving in the final allowed REQ cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          stall_c = 1'b1;
          if (misaligned) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            cnt_d   = 8'h0;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      laddr_q <= 3'b000;
      off_q   <= 2'b00;
      misal_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && valid) begin
        misal_q <= misaligned;
        if (!misaligned) begin
          laddr_q <= LAddr;
          off_q   <= Addr[1:0];
          we_q    <= is_store;
          addr_q  <= {Addr[31:2], 2'b00};
          wdata_q <= wdata_new;
          be_q    <= be_new;
        end
      end
      if (state_q == REQ && bus_ack && !we_q) rdata_q <= load_ext;
    end
  end

  // Stall is held low while reset is asserted, even if the core keeps driving a request.
  assign Stall     = rstn & stall_c;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign RData     = rdata_q;
  assign AddrErr   = (state_q == ERR) &  misal_q;
  assign BusErr    = (state_q == ERR) & ~misal_q;

endmodule

// File: tb/tb_dm_access.sv
// Directed bench for dm_access: drives load/store vectors, plays a bus slave with a
// programmable number of wait states and checks against hand-computed values.
module tb_dm_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [2:0]  LAddr;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Stall;
  logic        AddrErr;
  logic        BusErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk = 0;
  int n_bad = 0;

  int          req_cyc;
  int          stall_cyc;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic [31:0] cap_addr;
  logic        cap_we;
  logic        saw_aerr;
  logic        saw_berr;

  always #5 clk = ~clk;

  dm_access #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .LAddr     (LAddr),
    .Addr      (Addr),
    .WData     (WData),
    .RData     (RData),
    .Stall     (Stall),
    .AddrErr   (AddrErr),
    .BusErr    (BusErr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Runs one access from IDLE; the slave acks in REQ cycle number waits+1.
  task automatic access(input string name, input logic mr, input logic [1:0] mw,
                        input logic [2:0] la, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd);
    logic done = 1'b0;
    req_cyc   = 0;
    stall_cyc = 0;
    cap_be    = 4'h0;
    cap_wd    = 32'h0;
    cap_addr  = 32'h0;
    cap_we    = 1'b0;
    saw_aerr  = 1'b0;
    saw_berr  = 1'b0;
    MemRead   = mr;
    MemWrite  = mw;
    LAddr     = la;
    Addr      = a;
    WData     = wd;
    bus_rdata = rd;
    #1;
    for (int n = 0; n < 64; n++) begin
      saw_aerr = saw_aerr | AddrErr;
      saw_berr = saw_berr | BusErr;
      if (n > 0 && !Stall) begin
        done = 1'b1;
        break;
      end
      if (Stall) stall_cyc++;
      if (bus_req) begin
        req_cyc++;
        cap_be   = bus_be;
        cap_wd   = bus_wdata;
        cap_addr = bus_addr;
        cap_we   = bus_we;
      end
      bus_ack = bus_req && (req_cyc == waits + 1);
      @(posedge clk);
      #2;
    end
    chk_eq({name, "_finished"}, {31'h0, done}, 32'h1);
    bus_ack  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 2'b00;
    @(posedge clk);
    #2;
    chk_eq({name, "_err_one_cycle"}, {31'h0, AddrErr | BusErr}, 32'h0);
    $display("txn %s addr=0x%08h req=%0d stall=%0d be=%b wd=0x%08h we=%0b aerr=%0b berr=%0b rdata=0x%08h",
             name, a, req_cyc, stall_cyc, cap_be, cap_wd, cap_we, saw_aerr, saw_berr, RData);
  endtask

  initial begin
    rstn      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 2'b00;
    LAddr     = 3'b000;
    Addr      = 32'h0;
    WData     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk_eq("rst_stall",  {31'h0, Stall},   32'h0);
    chk_eq("rst_req",    {31'h0, bus_req}, 32'h0);
    chk_eq("rst_rdata",  RData,            32'h0);
    chk_eq("rst_be",     {28'h0, bus_be},  32'h0);
    chk_eq("rst_wdata",  bus_wdata,        32'h0);
    chk_eq("rst_addr",   bus_addr,         32'h0);
    chk_eq("rst_errs",   {30'h0, AddrErr, BusErr}, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #2;

    access("sb", 1'b0, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0);
    chk_eq("sb_be",    {28'h0, cap_be}, 32'h8);
    chk_eq("sb_wdata", cap_wd,          32'hABAB_ABAB);
    chk_eq("sb_we",    {31'h0, cap_we}, 32'h1);
    chk_eq("sb_addr",  cap_addr,        32'h0000_1000);
    chk_eq("sb_stall", stall_cyc,       32'd2);
    chk_eq("sb_req",   req_cyc,         32'd1);
    chk_eq("sb_rdata", RData,           32'h0);

    access("lb", 1'b1, 2'b00, 3'b001, 32'h0000_2001, 32'h0, 0, 32'h1234_80FF);
    chk_eq("lb_rdata", RData,           32'hFFFF_FF80);
    chk_eq("lb_be",    {28'h0, cap_be}, 32'h2);
    chk_eq("lb_we",    {31'h0, cap_we}, 32'h0);
    chk_eq("lb_wdata", cap_wd,          32'h0);
    chk_eq("lb_addr",  cap_addr,        32'h0000_2000);

    access("lbu", 1'b1, 2'b00, 3'b010, 32'h0000_2001, 32'h0, 0, 32'h1234_80FF);
    chk_eq("lbu_rdata", RData, 32'h0000_0080);

    access("lhu", 1'b1, 2'b00, 3'b100, 32'h0000_2002, 32'h0, 0, 32'h1234_80FF);
    chk_eq("lhu_rdata", RData,           32'h0000_1234);
    chk_eq("lhu_be",    {28'h0, cap_be}, 32'hC);

    access("lh_wait3", 1'b1, 2'b00, 3'b011, 32'h0000_3002, 32'h0, 3, 32'h9ABC_0000);
    chk_eq("lh_req",   req_cyc,           32'd4);
    chk_eq("lh_stall", stall_cyc,         32'd5);
    chk_eq("lh_rdata", RData,             32'hFFFF_9ABC);
    chk_eq("lh_berr",  {31'h0, saw_berr}, 32'h0);

    access("sw_mis", 1'b0, 2'b01, 3'b000, 32'h0000_4002, 32'h1111_2222, 0, 32'h0);
    chk_eq("sw_mis_aerr",  {31'h0, saw_aerr}, 32'h1);
    chk_eq("sw_mis_berr",  {31'h0, saw_berr}, 32'h0);
    chk_eq("sw_mis_req",   req_cyc,           32'd0);
    chk_eq("sw_mis_stall", stall_cyc,         32'd1);
    chk_eq("sw_mis_rdata", RData,             32'hFFFF_9ABC);

    access("lhu_mis", 1'b1, 2'b00, 3'b100, 32'h0000_2003, 32'h0, 0, 32'h0);
    chk_eq("lhu_mis_aerr", {31'h0, saw_aerr}, 32'h1);
    chk_eq("lhu_mis_req",  req_cyc,           32'd0);

    access("sh", 1'b0, 2'b11, 3'b000, 32'h0000_4002, 32'h0000_BEEF, 0, 32'h0);
    chk_eq("sh_be",    {28'h0, cap_be},   32'hC);
    chk_eq("sh_wdata", cap_wd,            32'hBEEF_BEEF);
    chk_eq("sh_aerr",  {31'h0, saw_aerr}, 32'h0);
    chk_eq("sh_rdata", RData,             32'hFFFF_9ABC);

    access("sw_wins", 1'b1, 2'b01, 3'b001, 32'h0000_7000, 32'h1122_3344, 0, 32'hFFFF_FFFF);
    chk_eq("sww_we",    {31'h0, cap_we},  32'h1);
    chk_eq("sww_be",    {28'h0, cap_be},  32'hF);
    chk_eq("sww_wdata", cap_wd,           32'h1122_3344);
    chk_eq("sww_rdata", RData,            32'hFFFF_9ABC);

    access("lw_tmo", 1'b1, 2'b00, 3'b000, 32'h0000_5000, 32'h0, 100, 32'hDEAD_BEEF);
    chk_eq("tmo_req",   req_cyc,           32'd4);
    chk_eq("tmo_berr",  {31'h0, saw_berr}, 32'h1);
    chk_eq("tmo_aerr",  {31'h0, saw_aerr}, 32'h0);
    chk_eq("tmo_rdata", RData,             32'hFFFF_9ABC);

    // Reset while a request is outstanding.
    MemRead = 1'b1;
    LAddr   = 3'b000;
    Addr    = 32'h0000_5100;
    bus_ack = 1'b0;
    @(posedge clk);
    #2;
    chk_eq("mid_req_up", {31'h0, bus_req}, 32'h1);
    rstn = 1'b0;
    #1;
    chk_eq("mid_rst_req",   {31'h0, bus_req}, 32'h0);
    chk_eq("mid_rst_stall", {31'h0, Stall},   32'h0);
    chk_eq("mid_rst_be",    {28'h0, bus_be},  32'h0);
    chk_eq("mid_rst_addr",  bus_addr,         32'h0);
    chk_eq("mid_rst_rdata", RData,            32'h0);
    $display("txn reset_mid_req req=%0b stall=%0b rdata=0x%08h", bus_req, Stall, RData);
    MemRead = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #2;

    access("lw_after_rst", 1'b1, 2'b00, 3'b000, 32'h0000_6004, 32'h0, 0, 32'hCAFE_F00D);
    chk_eq("lwr_rdata", RData,           32'hCAFE_F00D);
    chk_eq("lwr_be",    {28'h0, cap_be}, 32'hF);
    chk_eq("lwr_addr",  cap_addr,        32'h0000_6004);
    chk_eq("lwr_req",   req_cyc,         32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
